// File: rtl/i2c_m_bit_engine.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_m_bit_engine
//  Description : I2C master bit engine. Generates START, 8 data bits MSB
//                first, the ACK slot and STOP on open-drain enables. All bus
//                timing is derived from one quarter-period counter.
//                Optional macro I2C_M_SLAVE_STRETCH_EN lets a slave stretch
//                SCL in every quarter where the master releases SCL.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_m_bit_engine #(
    parameter int CLK_DIV = 67
) (
    input  logic       sys_clk_i,
    input  logic       rst_i,
    input  logic       start_req_i,
    input  logic       data_rdy_i,
    input  logic       stop_req_i,
    input  logic [7:0] wdata_i,
    output logic       scl_stretch_o,
    output logic       ack_ok_o,
    output logic       ack_ng_o,
    output logic       busy_o,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe_o,
    output logic       sda_oe_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_BIT    = 3'd2;
    localparam logic [2:0] ST_ACK    = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_STOP_A = 3'd5;
    localparam logic [2:0] ST_STOP_B = 3'd6;
    localparam logic [2:0] ST_STOP_C = 3'd7;

    localparam logic [7:0] C_QMAX = 8'(CLK_DIV - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] qcnt_q,  qcnt_d;
    logic [1:0] qidx_q,  qidx_d;
    logic [2:0] bidx_q,  bidx_d;
    logic [7:0] shreg_q, shreg_d;
    logic       ackbit_q, ackbit_d;
    logic       ack_ok_q, ack_ok_d;
    logic       ack_ng_q, ack_ng_d;

    logic       w_rel_quarter;
    logic       w_hold;
    logic       w_tick;
    logic       w_timed;

    // Quarters in which the master lets SCL float high
    assign w_rel_quarter = (((state_q == ST_BIT) || (state_q == ST_ACK)) && (qidx_q == 2'd2))
                         || (state_q == ST_STOP_B);

`ifdef I2C_M_SLAVE_STRETCH_EN
    // A slave holding SCL low freezes the quarter before it starts
    assign w_hold = w_rel_quarter && (qcnt_q == 8'd0) && !scl_i;
`else
    logic w_unused_scl;
    assign w_unused_scl = scl_i & w_rel_quarter;
    assign w_hold       = 1'b0;
`endif

    assign w_tick  = (qcnt_q == C_QMAX) && !w_hold;
    assign w_timed = (state_q != ST_IDLE) && (state_q != ST_HOLD);

    // Next-state, counters, shift register and ACK pulse generation
    always_comb begin
        state_d  = state_q;
        qidx_d   = qidx_q;
        bidx_d   = bidx_q;
        shreg_d  = shreg_q;
        ackbit_d = ackbit_q;
        ack_ok_d = 1'b0;
        ack_ng_d = 1'b0;

        if (!w_timed || w_tick) begin
            qcnt_d = 8'd0;
        end else if (w_hold) begin
            qcnt_d = qcnt_q;
        end else begin
            qcnt_d = qcnt_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_req_i) begin
                    state_d = ST_START;
                    shreg_d = wdata_i;
                    qidx_d  = 2'd0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    state_d = ST_BIT;
                    bidx_d  = 3'd7;
                    qidx_d  = 2'd0;
                end
            end
            ST_BIT: begin
                if (w_tick) begin
                    qidx_d = qidx_q + 2'd1;
                    if (qidx_q == 2'd3) begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                        if (bidx_q == 3'd0) begin
                            state_d = ST_ACK;
                        end else begin
                            bidx_d = bidx_q - 3'd1;
                        end
                    end
                end
            end
            ST_ACK: begin
                if (w_tick) begin
                    qidx_d = qidx_q + 2'd1;
                    // Sample on the last cycle of the SCL-high quarter
                    if (qidx_q == 2'd2) begin
                        ackbit_d = sda_i;
                    end
                    if (qidx_q == 2'd3) begin
                        if (!ackbit_q) begin
                            state_d  = ST_HOLD;
                            ack_ok_d = 1'b1;
                        end else begin
                            state_d  = ST_STOP_A;
                            ack_ng_d = 1'b1;
                        end
                    end
                end
            end
            ST_HOLD: begin
                // STOP takes priority over a simultaneous data request
                if (stop_req_i) begin
                    state_d = ST_STOP_A;
                end else if (data_rdy_i) begin
                    state_d = ST_BIT;
                    shreg_d = wdata_i;
                    bidx_d  = 3'd7;
                    qidx_d  = 2'd0;
                end
            end
            ST_STOP_A: if (w_tick) state_d = ST_STOP_B;
            ST_STOP_B: if (w_tick) state_d = ST_STOP_C;
            ST_STOP_C: if (w_tick) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            qcnt_q   <= 8'd0;
            qidx_q   <= 2'd0;
            bidx_q   <= 3'd0;
            shreg_q  <= 8'h00;
            ackbit_q <= 1'b0;
            ack_ok_q <= 1'b0;
            ack_ng_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            qcnt_q   <= qcnt_d;
            qidx_q   <= qidx_d;
            bidx_q   <= bidx_d;
            shreg_q  <= shreg_d;
            ackbit_q <= ackbit_d;
            ack_ok_q <= ack_ok_d;
            ack_ng_q <= ack_ng_d;
        end
    end

    // Line drive decoded from state; SDA drives low for a 0 bit
    always_comb begin
        scl_oe_o = 1'b0;
        sda_oe_o = 1'b0;
        case (state_q)
            ST_START:  begin scl_oe_o = 1'b0;             sda_oe_o = 1'b1;        end
            ST_BIT:    begin scl_oe_o = (qidx_q < 2'd2);  sda_oe_o = ~shreg_q[7]; end
            ST_ACK:    begin scl_oe_o = (qidx_q < 2'd2);  sda_oe_o = 1'b0;        end
            ST_HOLD:   begin scl_oe_o = 1'b1;             sda_oe_o = 1'b1;        end
            ST_STOP_A: begin scl_oe_o = 1'b1;             sda_oe_o = 1'b1;        end
            ST_STOP_B: begin scl_oe_o = 1'b0;             sda_oe_o = 1'b1;        end
            default:   begin scl_oe_o = 1'b0;             sda_oe_o = 1'b0;        end
        endcase
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign scl_stretch_o = (state_q == ST_HOLD);
    assign ack_ok_o      = ack_ok_q;
    assign ack_ng_o      = ack_ng_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_m_bit_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_m_bit_engine
//  Description : Self-checking bench for i2c_m_bit_engine (CLK_DIV = 4).
//                Expected bus timing comes from quarter-period arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_m_bit_engine;

    localparam int D     = 4;
    localparam int LIMIT = 400;
`ifdef I2C_M_SLAVE_STRETCH_EN
    localparam int STRETCH_EN = 1;
`else
    localparam int STRETCH_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_req = 1'b0;
    logic       data_rdy = 1'b0;
    logic       stop_req = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       slave_scl_low = 1'b0;
    logic       slave_sda_low = 1'b0;
    logic       scl_stretch, ack_ok, ack_ng, busy, scl_oe, sda_oe;
    logic       scl_line, sda_line;

    int errors = 0;
    int checks = 0;

    // Wired-AND open-drain bus with an optional slave pulling each line
    assign scl_line = ~scl_oe & ~slave_scl_low;
    assign sda_line = ~sda_oe & ~slave_sda_low;

    always #5 clk = ~clk;

    i2c_m_bit_engine #(.CLK_DIV(D)) dut (
        .sys_clk_i     (clk),
        .rst_i         (rst),
        .start_req_i   (start_req),
        .data_rdy_i    (data_rdy),
        .stop_req_i    (stop_req),
        .wdata_i       (wdata),
        .scl_stretch_o (scl_stretch),
        .ack_ok_o      (ack_ok),
        .ack_ng_o      (ack_ng),
        .busy_o        (busy),
        .scl_i         (scl_line),
        .sda_i         (sda_line),
        .scl_oe_o      (scl_oe),
        .sda_oe_o      (sda_oe)
    );

    // Reference: a byte costs 36 quarters plus START (1 quarter) for an
    // address; the pulse appears one cycle after the last quarter ends.
    function automatic int exp_pulse(input bit is_start, input int stretch);
        return (is_start ? 37 : 36) * D + 1 + (STRETCH_EN != 0 ? stretch : 0);
    endfunction

    // Issue one byte request and observe the bus until the ACK pulse (+post)
    task automatic run_xfer(input bit is_start, input logic [7:0] data, input bit nack,
                            input int stretch_len, input bit noise, input int post,
                            output int pulse_cyc, output int kind, output int npulses,
                            output logic [7:0] bits, output int nedges,
                            output bit stretch_at_pulse, output int idle_cyc);
        bit prev_scl_oe;
        int rel_at;
        pulse_cyc = -1; kind = 0; npulses = 0; bits = 8'h00; nedges = 0;
        stretch_at_pulse = 1'b0; idle_cyc = -1; rel_at = -1;
        @(negedge clk);
        prev_scl_oe = scl_oe;
        start_req = is_start;
        data_rdy  = !is_start;
        wdata     = data;
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            start_req = 1'b0; data_rdy = 1'b0; stop_req = 1'b0;
            wdata = 8'($urandom);
            if (k == rel_at) slave_scl_low = 1'b0;
            if (prev_scl_oe && !scl_oe) begin
                if (nedges < 8) bits = {bits[6:0], sda_line};
                nedges++;
                if (nedges == 9 && stretch_len > 0) begin
                    slave_scl_low = 1'b1;
                    rel_at = k + stretch_len;
                end
            end
            prev_scl_oe = scl_oe;
            if (nedges >= 8 && pulse_cyc < 0) slave_sda_low = !nack;
            if (ack_ok || ack_ng) begin
                npulses++;
                if (pulse_cyc < 0) begin
                    pulse_cyc = k;
                    kind = ack_ok ? 1 : 2;
                    stretch_at_pulse = scl_stretch;
                    slave_sda_low = 1'b0;
                end
            end
            if (pulse_cyc >= 0 && idle_cyc < 0 && !busy) idle_cyc = k;
            if (noise && pulse_cyc < 0) begin
                start_req = ($urandom_range(0, 7) == 0);
                data_rdy  = ($urandom_range(0, 7) == 0);
                stop_req  = ($urandom_range(0, 7) == 0);
            end
            if (pulse_cyc >= 0 && k >= pulse_cyc + post) break;
        end
        start_req = 1'b0; data_rdy = 1'b0; stop_req = 1'b0;
        slave_scl_low = 1'b0; slave_sda_low = 1'b0;
    endtask

    // Issue a STOP (optionally together with data_rdy) from HOLD and observe
    task automatic run_stop(input bit with_data, output int edges, output int pulses,
                            output int scl_rise, output int sda_rise, output int idle_cyc);
        bit prev_scl_oe, prev_sda_oe;
        edges = 0; pulses = 0; scl_rise = -1; sda_rise = -1; idle_cyc = -1;
        @(negedge clk);
        prev_scl_oe = scl_oe; prev_sda_oe = sda_oe;
        stop_req = 1'b1;
        data_rdy = with_data;
        wdata    = 8'($urandom);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            stop_req = 1'b0; data_rdy = 1'b0;
            if (prev_scl_oe && !scl_oe) begin
                edges++;
                if (scl_rise < 0) scl_rise = k;
            end
            if (prev_sda_oe && !sda_oe && !scl_oe && sda_rise < 0) sda_rise = k;
            prev_scl_oe = scl_oe; prev_sda_oe = sda_oe;
            if (ack_ok || ack_ng) pulses++;
            if (!busy) begin
                idle_cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({scl_oe, sda_oe, scl_stretch, ack_ok, ack_ng, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {scl_oe, sda_oe, scl_stretch, ack_ok, ack_ng, busy});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_address_frame();
        int pc, kd, np, ne, ic;
        logic [7:0] bt;
        bit sp;
        run_xfer(1'b1, 8'h60, 1'b0, 0, 1'b0, 3, pc, kd, np, bt, ne, sp, ic);
        checks++;
        if (bt !== 8'h60) begin errors++; $display("FAIL addr_bits: got %02h expected 60", bt); end
        checks++;
        if (pc !== exp_pulse(1'b1, 0)) begin
            errors++; $display("FAIL addr_pulse_cycle: got %0d expected %0d", pc, exp_pulse(1'b1, 0));
        end
        checks++;
        if (kd !== 1 || np !== 1) begin
            errors++; $display("FAIL addr_ack_kind: got kind=%0d pulses=%0d expected kind=1 pulses=1", kd, np);
        end
        checks++;
        if (sp !== 1'b1) begin errors++; $display("FAIL addr_stretch_at_pulse: got %b expected 1", sp); end
        checks++;
        if ({scl_stretch, busy, scl_oe, sda_oe} !== 4'b1111) begin
            errors++; $display("FAIL addr_hold_state: got %b expected 1111", {scl_stretch, busy, scl_oe, sda_oe});
        end
    endtask

    task automatic test_data_bytes();
        int pc, kd, np, ne, ic;
        logic [7:0] bt, d;
        bit sp;
        for (int i = 0; i < 4; i++) begin
            d = (i == 0) ? 8'hA5 : 8'($urandom);
            run_xfer(1'b0, d, 1'b0, 0, 1'b1, 2, pc, kd, np, bt, ne, sp, ic);
            checks++;
            if (bt !== d) begin errors++; $display("FAIL data_bits[%0d]: got %02h expected %02h", i, bt, d); end
            checks++;
            if (pc !== exp_pulse(1'b0, 0)) begin
                errors++; $display("FAIL data_pulse_cycle[%0d]: got %0d expected %0d", i, pc, exp_pulse(1'b0, 0));
            end
            checks++;
            if (kd !== 1 || np !== 1 || sp !== 1'b1) begin
                errors++; $display("FAIL data_ack[%0d]: got kind=%0d pulses=%0d stretch=%b expected 1 1 1", i, kd, np, sp);
            end
        end
    endtask

    task automatic test_hold_ignores_start();
        bit bad;
        bad = 1'b0;
        @(negedge clk);
        start_req = 1'b1;
        wdata = 8'h3C;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start_req = 1'b0;
            if ({scl_stretch, busy, scl_oe, sda_oe, ack_ok, ack_ng} !== 6'b111100) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL hold_start_ignored: got state change expected HOLD kept"); end
    endtask

    task automatic test_stop(input bit with_data);
        int ed, pu, sr, dr, ic;
        run_stop(with_data, ed, pu, sr, dr, ic);
        checks++;
        if (ed !== 1 || pu !== 0) begin
            errors++; $display("FAIL stop_no_byte(d=%0d): got edges=%0d pulses=%0d expected 1 0", with_data, ed, pu);
        end
        checks++;
        if (sr !== D + 1 || dr !== 2 * D + 1) begin
            errors++; $display("FAIL stop_timing(d=%0d): got scl=%0d sda=%0d expected %0d %0d", with_data, sr, dr, D + 1, 2 * D + 1);
        end
        checks++;
        if (ic !== 3 * D + 1) begin
            errors++; $display("FAIL stop_idle(d=%0d): got %0d expected %0d", with_data, ic, 3 * D + 1);
        end
    endtask

    task automatic test_nack();
        int pc, kd, np, ne, ic;
        logic [7:0] bt, d;
        bit sp;
        d = 8'($urandom);
        run_xfer(1'b1, d, 1'b1, 0, 1'b1, 20, pc, kd, np, bt, ne, sp, ic);
        checks++;
        if (bt !== d) begin errors++; $display("FAIL nack_bits: got %02h expected %02h", bt, d); end
        checks++;
        if (pc !== exp_pulse(1'b1, 0) || kd !== 2 || np !== 1) begin
            errors++; $display("FAIL nack_pulse: got cyc=%0d kind=%0d n=%0d expected %0d 2 1", pc, kd, np, exp_pulse(1'b1, 0));
        end
        checks++;
        if (sp !== 1'b0) begin errors++; $display("FAIL nack_stretch: got %b expected 0", sp); end
        checks++;
        if (ic - pc !== 3 * D) begin
            errors++; $display("FAIL nack_busy_fall: got %0d expected %0d", ic - pc, 3 * D);
        end
    endtask

    task automatic test_reset_mid();
        int pc, kd, np, ne, ic;
        logic [7:0] bt, d;
        bit sp;
        @(negedge clk);
        start_req = 1'b1;
        wdata = 8'h00;
        @(negedge clk);
        start_req = 1'b0;
        // bit 3 Q0 starts after START + 4 bits
        repeat (D + 4 * 4 * D) @(negedge clk);
        checks++;
        if ({busy, scl_oe, sda_oe} !== 3'b111) begin
            errors++; $display("FAIL midreset_pre: got %b expected 111", {busy, scl_oe, sda_oe});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({scl_oe, sda_oe, busy, scl_stretch} !== 4'b0000) begin
            errors++; $display("FAIL midreset_release: got %b expected 0000", {scl_oe, sda_oe, busy, scl_stretch});
        end
        rst = 1'b0;
        d = 8'($urandom);
        run_xfer(1'b1, d, 1'b0, 0, 1'b0, 2, pc, kd, np, bt, ne, sp, ic);
        checks++;
        if (bt !== d || pc !== exp_pulse(1'b1, 0) || kd !== 1) begin
            errors++; $display("FAIL midreset_reframe: got bits=%02h cyc=%0d kind=%0d expected %02h %0d 1", bt, pc, kd, d, exp_pulse(1'b1, 0));
        end
    endtask

    task automatic test_slave_stretch();
        int pc, kd, np, ne, ic;
        logic [7:0] bt, d;
        bit sp;
        d = 8'($urandom);
        run_xfer(1'b1, d, 1'b0, 10, 1'b0, 2, pc, kd, np, bt, ne, sp, ic);
        checks++;
        if (pc !== exp_pulse(1'b1, 10) || kd !== 1 || bt !== d) begin
            errors++; $display("FAIL slave_stretch: got cyc=%0d kind=%0d bits=%02h expected %0d 1 %02h", pc, kd, bt, exp_pulse(1'b1, 10), d);
        end
    endtask

    task automatic test_idle_ignore();
        bit bad;
        bad = 1'b0;
        @(negedge clk);
        data_rdy = 1'b1;
        @(negedge clk);
        data_rdy = 1'b0;
        stop_req = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            stop_req = 1'b0;
            if ({busy, scl_oe, sda_oe, ack_ok, ack_ng} !== 5'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL idle_ignore: got activity expected idle"); end
    endtask

    initial begin
        test_reset();
        test_address_frame();
        test_data_bytes();
        test_hold_ignores_start();
        test_stop(1'b1);
        test_nack();
        test_reset_mid();
        test_stop(1'b0);
        test_slave_stretch();
        test_stop(1'b0);
        test_idle_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_m_bit_engine.md
I2C_M_BIT_ENGINE -- requirements
Module: i2c_m_bit_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 67, meaning sys_clk_i cycles per SCL quarter-period (67 gives ~100 kHz at 27 MHz); legal range 2..255.
REQ-002 SHALL have port sys_clk_i  input  1  system clock; the single clock of the block.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start_req_i  input  1  one-cycle request: START condition plus the address byte from wdata_i.
REQ-005 SHALL have port data_rdy_i  input  1  one-cycle request: send the next byte from wdata_i.
REQ-006 SHALL have port stop_req_i  input  1  one-cycle request: STOP condition.
REQ-007 SHALL have port wdata_i  input  8  byte to transmit, MSB first.
REQ-008 SHALL have port scl_stretch_o  output  1  level; SCL is held low after ACK and a data or stop request is awaited.
REQ-009 SHALL have port ack_ok_o  output  1  one-cycle pulse; the slave ACKed (SDA low).
REQ-010 SHALL have port ack_ng_o  output  1  one-cycle pulse; the slave NACKed (SDA high).
REQ-011 SHALL have port busy_o  output  1  level; high in every state except IDLE.
REQ-012 SHALL have port scl_i, sda_i  input  1 each  synchronized bus line levels.
REQ-013 SHALL have port scl_oe_o, sda_oe_o  output  1 each  open-drain enables; 1 pulls the line low, 0 releases it.

Function
REQ-014 SHALL implement the states IDLE, START, BIT, ACK, HOLD, STOP_A, STOP_B, STOP_C; all timing derives from one quarter counter that wraps at CLK_DIV-1.
REQ-015 IDLE: both lines released; start_req_i moves to START and latches wdata_i in the same cycle; data_rdy_i and stop_req_i are ignored.
REQ-016 START: SDA low and SCL released for 1 quarter; then SCL is pulled low and the block enters BIT with bit index 7.
REQ-017 BIT: each bit takes 4 quarters:
- Q0/Q1: SCL low, SDA driven from the latched bit at the start of Q0.
- Q2/Q3: SCL released.
- After Q3 of bit 0, go to ACK.
REQ-018 ACK: SDA released for all 4 quarters; sda_i is sampled on the last cycle of Q2.
REQ-019 At the end of ACK, SCL is pulled low and exactly one of ack_ok_o/ack_ng_o pulses in the first cycle of SCL low.
REQ-020 After ACK=0: enter HOLD; scl_stretch_o is asserted in that same cycle and stays high until a request is accepted.
REQ-021 After ACK=1 (NACK): skip HOLD and generate STOP autonomously.
REQ-022 HOLD: SCL low, SDA low.
- data_rdy_i latches wdata_i and enters BIT (index 7).
- stop_req_i enters STOP_A.
- If both arrive in the same cycle, stop_req_i wins.
- start_req_i is ignored (no repeated START).
- scl_stretch_o drops the cycle after acceptance.
REQ-023 STOP sequence, 1 quarter each, then IDLE:
- STOP_A: SCL low, SDA low.
- STOP_B: SCL released, SDA low.
- STOP_C: both lines released.
REQ-024 Requests arriving in START, BIT, ACK or STOP_* SHALL be ignored (not queued).
REQ-025 A 1-byte frame from start_req_i to ack pulse SHALL take exactly (1+36)*CLK_DIV+1 cycles.

Reset
REQ-026 While rst_i is high at a clock edge:
- state returns to IDLE and all counters clear;
- scl_oe_o, sda_oe_o, scl_stretch_o, ack_ok_o, ack_ng_o and busy_o are 0 in the following cycle;
- the shift register clears to 0x00.
REQ-027 Reset mid-transfer SHALL release both lines immediately, with no STOP generated.

Configuration
REQ-028 The macro I2C_M_SLAVE_STRETCH_EN controls slave clock stretching.
- Defined: in every quarter where SCL is released (BIT/ACK Q2, STOP_B), the quarter counter holds at 0 while scl_i reads 0, so the quarter starts when the slave releases SCL.
- Undefined: scl_i is ignored and timing is purely counter-based.

Verification
REQ-029 CLK_DIV=4, start_req_i with wdata_i=0x60, slave ACKs -> SDA shows 0,1,1,0,0,0,0,0 on SCL rising edges; ack_ok_o pulses at cycle 149; scl_stretch_o is high from cycle 149.
REQ-030 In HOLD, data_rdy_i with 0xA5 -> bits 1,0,1,0,0,1,0,1 sent; ack_ok_o pulses 145 cycles after data_rdy_i.
REQ-031 Slave NACKs the address -> ack_ng_o pulses, scl_stretch_o stays 0, the STOP sequence follows, and busy_o falls 12 cycles after the pulse.
REQ-032 In HOLD, data_rdy_i and stop_req_i in the same cycle -> STOP is generated and no byte is sent.
REQ-033 rst_i asserted during bit 3 -> scl_oe_o=sda_oe_o=0 the next cycle; a subsequent start_req_i runs a normal frame.
REQ-034 With I2C_M_SLAVE_STRETCH_EN defined, scl_i held low 10 cycles in ACK Q2 -> the ack pulse is delayed by exactly 10 cycles; with the macro undefined, the delay is 0.
